// File: rtl/mult_unit.sv
// mult_unit: multi-cycle shift-and-add multiplier for MIPS MULT/MULTU,
// holding the architectural HI/LO registers.
// Optional build macro: MULT_EARLY_EXIT_EN (leave RUN once the remaining
// multiplier bits are zero, then right-align the product in FIX).
`timescale 1ns/1ps

// 4-bit-group carry-lookahead adder; WIDTH must be a multiple of 4.
module adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int unsigned GROUPS = WIDTH / 4;

  logic [WIDTH-1:0]  g;
  logic [WIDTH-1:0]  p;
  logic [WIDTH-1:0]  c;
  logic [GROUPS:0]   gc;

  // Lookahead inside each group, group carries chained between groups
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    c  = '0;
    gc = '0;
    gc[0] = c0;
    for (int unsigned k = 0; k < GROUPS; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      gc[k+1]  = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    sum  = p ^ c;
    cout = gc[GROUPS];
  end
endmodule

module mult_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int unsigned CNT_W = 6;
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH:0]   acc, acc_n;
  logic [WIDTH-1:0] mcand, mcand_n;
  logic [WIDTH-1:0] mplier, mplier_n;
  logic             neg, neg_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             busy_n, done_n;
  logic [WIDTH-1:0] hi_n, lo_n;

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH:0]   acc_add;
  logic [PW-1:0]    prod;
  logic             run_last;

  // Single add datapath: accumulator plus multiplicand
  adder #(.WIDTH(WIDTH)) u_adder (
    .a    (acc[WIDTH-1:0]),
    .b    (mcand),
    .c0   (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

`ifdef MULT_EARLY_EXIT_EN
  logic rem_any;

  // Any unconsumed multiplier bit left after this cycle's shift
  always_comb begin
    rem_any = 1'b0;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      if (i + 32'(cnt) < WIDTH) rem_any = rem_any | mplier[i];
    end
  end

  assign run_last = (cnt == CNT_W'(WIDTH - 1)) || !rem_any;
`else
  assign run_last = (cnt == CNT_W'(WIDTH - 1));
`endif

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      neg    <= neg_n;
      cnt    <= cnt_n;
      busy   <= busy_n;
      done   <= done_n;
      hi     <= hi_n;
      lo     <= lo_n;
    end
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    mcand_n  = mcand;
    mplier_n = mplier;
    neg_n    = neg;
    cnt_n    = cnt;
    hi_n     = hi;
    lo_n     = lo;
    done_n   = 1'b0;
    acc_add  = acc;
    prod     = {acc[WIDTH-1:0], mplier};

    case (state)
      IDLE: begin
        if (start) begin
          mcand_n  = (is_signed && a[WIDTH-1]) ? WIDTH'(~a + WIDTH'(1)) : a;
          mplier_n = (is_signed && b[WIDTH-1]) ? WIDTH'(~b + WIDTH'(1)) : b;
          neg_n    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_n    = '0;
          cnt_n    = '0;
          state_n  = RUN;
        end
      end
      RUN: begin
        if (mplier[0]) acc_add = {add_cout, add_sum};
        acc_n    = {1'b0, acc_add[WIDTH:1]};
        mplier_n = {acc_add[0], mplier[WIDTH-1:1]};
        cnt_n    = cnt + CNT_W'(1);
        if (run_last) state_n = FIX;
      end
      FIX: begin
`ifdef MULT_EARLY_EXIT_EN
        // cnt now equals RUN cycles taken; shift out the unused positions
        prod = prod >> (WIDTH - 32'(cnt));
`endif
        if (neg) prod = ~prod + PW'(1);
        acc_n    = {1'b0, prod[PW-1:WIDTH]};
        mplier_n = prod[WIDTH-1:0];
        hi_n     = prod[PW-1:WIDTH];
        lo_n     = prod[WIDTH-1:0];
        done_n   = 1'b1;
        state_n  = DONE;
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end
endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed self-checking bench for mult_unit.
`timescale 1ns/1ps

module tb_mult_unit;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int failures = 0;
  logic [2*W-1:0] prev_prod = '0;

  always #5 clk = ~clk;

  mult_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Cycle of the done pulse, counting the start-sampling edge as edge 0
  function automatic int exp_lat(input logic s, input logic [W-1:0] bv);
    logic [W-1:0] m;
    int runs;
    int lat;
    m = (s && bv[W-1]) ? (~bv + 32'd1) : bv;
    runs = 1;
    for (int i = 0; i < int'(W); i++) if (m[i]) runs = i + 1;
    lat = runs + 2;
`ifndef MULT_EARLY_EXIT_EN
    lat = 34;
`endif
    return lat;
  endfunction

  // One operation observed over a fixed 40-cycle window
  task automatic run_op(input string tag, input logic s, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [63:0] exp_prod,
                        input logic inject);
    int lat;
    int done_cyc;
    int done_cnt;
    logic busy_ok;
    logic hold_ok;
    logic [63:0] got;
    lat = exp_lat(s, bv);
    done_cyc = 0;
    done_cnt = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    got = '0;
    @(negedge clk);
    start = 1'b1; is_signed = s; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; is_signed = ~s;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc = cyc;
          got = {hi, lo};
        end
      end
      if (busy !== (cyc <= lat)) busy_ok = 1'b0;
      if (cyc < lat && {hi, lo} !== prev_prod) hold_ok = 1'b0;
      if (inject && (cyc == 5 || cyc == 20)) begin
        start = 1'b1; a = $urandom; b = $urandom; is_signed = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_latency"}, 64'(done_cyc), 64'(lat));
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_busy_window"}, 64'(busy_ok), 64'd1);
    check({tag, "_hilo_hold"}, 64'(hold_ok), 64'd1);
    check({tag, "_product"}, got, exp_prod);
    check({tag, "_product_after"}, {hi, lo}, exp_prod);
    prev_prod = exp_prod;
  endtask

  initial begin
    logic done_seen;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;

    // Boundary and sign cases
    run_op("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    run_op("mult_m1x1", 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run_op("multu_m1x1", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b0);
    run_op("mult_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    run_op("mult_minx2", 1'b1, 32'h8000_0000, 32'h0000_0002, 64'hFFFF_FFFF_0000_0000, 1'b0);

    // Starts while busy are ignored
    run_op("first_op", 1'b0, 32'h1234_5678, 32'h0001_0000, 64'h0000_1234_5678_0000, 1'b0);
    run_op("ignored_starts", 1'b0, 32'h0000_0003, 32'h8000_0001, 64'h0000_0001_8000_0003, 1'b1);

    // Asynchronous reset in the middle of cycle 10
    @(negedge clk);
    start = 1'b1; is_signed = 1'b1; a = 32'd7; b = 32'h8000_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    done_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) done_seen = 1'b1;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    prev_prod = '0;
    run_op("after_abort", 1'b1, 32'hFFFF_FFF9, 32'h0000_0006, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);

    // Small operands and zero
    run_op("multu_5x3", 1'b0, 32'd5, 32'd3, 64'd15, 1'b0);
    run_op("mult_zero", 1'b1, 32'd0, 32'd0, 64'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Multi-cycle shift-and-add multiplier serving MIPS MULT/MULTU.
- Sits beside the ALU in the execute stage and holds the architectural HI/LO registers.
- The controller stalls the pipeline on `busy`.
- Internally drives one instance of the 32-bit carry-lookahead `adder` each cycle as its add datapath, feeding it the partial-product accumulator and the multiplicand.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; the accumulator is WIDTH+1 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
- a  input  WIDTH  multiplicand; sampled with start
- b  input  WIDTH  multiplier; sampled with start
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when HI/LO have just been updated
- hi  output  WIDTH  architectural HI (upper product half)
- lo  output  WIDTH  architectural LO (lower product half)

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, busy=0, done=0, hi=0, lo=0, and all working registers are cleared.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 at a rising edge captures the operands and goes to RUN.
  - If is_signed=1, the block stores |a| and |b| and records neg = a[MSB] XOR b[MSB]. Otherwise it stores a and b unchanged and neg=0.
  - |0x80000000| is 0x80000000 taken as unsigned.
  - A 6-bit step counter is set to 0.
- RUN, once per cycle:
  - If the multiplier LSB is 1, acc = acc + mcand through the adder, with c0=0 and cout forming the accumulator MSB. Otherwise acc is unchanged.
  - {acc, mplier} then shifts right by 1.
  - The counter increments. When the counter reaches WIDTH-1 in RUN, the next state is FIX.
- FIX: always exactly one cycle. If neg=1, the 2*WIDTH product is replaced by its two's complement: the bitwise inverse plus 1, with the carry propagated from the low half into the high half. Next state is DONE.
- DONE: hi/lo are loaded from the working product and done=1 for this cycle only. Next state is IDLE.
- busy=1 in RUN, FIX and DONE; busy=0 in IDLE.
- Latency: start sampled at edge 0 gives RUN for cycles 1..32, FIX at cycle 33, and done=1 with new hi/lo visible during cycle 34. A new start can be sampled at the edge ending cycle 34 only if the state is IDLE, i.e. earliest at edge 35.
- hi/lo hold their previous values throughout RUN/FIX and change only on entry to DONE.
- start while busy=1 is ignored: no re-capture and no queuing.
- Operands a/b/is_signed may change freely after capture.
- rst_n asserted mid-operation aborts immediately with no done pulse, and HI/LO are cleared.
- Zero operand: the full 34-cycle sequence still runs and the result is 0/0.
- The product is exact, with no overflow: the 2*WIDTH result always fits.

Optional Feature:
- Macro MULT_EARLY_EXIT_EN.
- When defined, RUN also exits to FIX at the end of any RUN cycle in which the remaining (post-shift) multiplier bits are all zero. The accumulator/product are right-aligned by shifting the remaining (WIDTH-1-counter) positions in FIX, using a barrel shift.
- Minimum one RUN cycle. Results are bit-identical to the non-early-exit case; only latency shrinks.
- When undefined, latency is fixed at 34 cycles regardless of operands.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1..34.
- MULT a=0xFFFFFFFF (-1) b=0x00000001 -> hi=0xFFFFFFFF, lo=0xFFFFFFFF; the same operands with MULTU -> hi=0x00000000, lo=0xFFFFFFFF.
- MULT a=0x80000000 b=0x80000000 -> hi=0x40000000, lo=0x00000000; MULT a=0x80000000 b=0x00000002 -> hi=0xFFFFFFFF, lo=0x00000000.
- First operation gives hi=0x12345678-derived result. Pulse start with new operands at cycles 5 and 20 of a second operation -> both ignored; hi/lo keep the first result until the second done, and only one done pulse occurs.
- Assert rst_n=0 asynchronously (mid-clock) at cycle 10 of a multiply -> busy, hi, lo drop to 0 immediately; no done pulse; the next start after release completes normally.
- With MULT_EARLY_EXIT_EN: MULTU a=5 b=3 -> RUN for 2 cycles, done at cycle 4, hi=0, lo=15. Without the macro -> same values, done at cycle 34.
